// File: rtl/wide_add_sequencer_if.sv
// ============================================================================
//  Module      : wide_add_sequencer_if
//  Description : Command / result handshake bundle for wide_add_sequencer.
//                The requester drives the command and done_ready; the
//                sequencer drives start_ready, the result and its flags.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface wide_add_sequencer_if #(
   parameter int WORDS = 4
);
   localparam int N = 16 * WORDS;

   logic          start_valid;
   logic          start_ready;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic          sub;
   logic          carryIn;
   logic [N-1:0]  result;
   logic          carryOut;
   logic          overflow;
   logic          done_valid;
   logic          done_ready;
   logic          busy;

   // Requester side
   modport master (
      output start_valid, a, b, sub, carryIn, done_ready,
      input  start_ready, result, carryOut, overflow, done_valid, busy
   );

   // Sequencer side
   modport slave (
      input  start_valid, a, b, sub, carryIn, done_ready,
      output start_ready, result, carryOut, overflow, done_valid, busy
   );
endinterface

`default_nettype wire

// File: rtl/wide_add_sequencer.sv
// ============================================================================
//  Module      : wide_add_sequencer
//  Description : WORDS x 16-bit add/subtract built from a single 16-bit
//                carry-select adder. One slice per cycle, LSB first, with
//                the carry chained through a register.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wide_add_sequencer #(
   parameter int WORDS = 4
) (
   input  wire logic            clk,
   input  wire logic            rst,
   wide_add_sequencer_if.slave  bus
);

   localparam int N     = 16 * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q,     state_d;
   logic [N-1:0]       op_a_q,      op_a_d;
   logic [N-1:0]       op_b_q,      op_b_d;
   logic [N-1:0]       result_q,    result_d;
   logic               carry_q,     carry_d;
   logic [IDX_W-1:0]   idx_q,       idx_d;
   logic               carry_out_q, carry_out_d;
   logic               overflow_q,  overflow_d;

   // ------------------------------------------------------------------------
   // 16-bit carry-select adder: low byte ripples, high byte is precomputed
   // for both possible carries and chosen by the low-byte carry.
   // ------------------------------------------------------------------------
   logic [15:0] w_slice_a;
   logic [15:0] w_slice_b;
   logic [8:0]  w_lo;
   logic [8:0]  w_hi0;
   logic [8:0]  w_hi1;
   logic [15:0] w_sum;
   logic        w_cout;

   assign w_slice_a = op_a_q[16*idx_q +: 16];
   assign w_slice_b = op_b_q[16*idx_q +: 16];

   // Slice adder datapath (purely combinational, no pipeline stage)
   always_comb begin
      w_lo   = {1'b0, w_slice_a[7:0]}  + {1'b0, w_slice_b[7:0]}  + {8'd0, carry_q};
      w_hi0  = {1'b0, w_slice_a[15:8]} + {1'b0, w_slice_b[15:8]};
      w_hi1  = {1'b0, w_slice_a[15:8]} + {1'b0, w_slice_b[15:8]} + 9'd1;
      w_sum  = {(w_lo[8] ? w_hi1[7:0] : w_hi0[7:0]), w_lo[7:0]};
      w_cout = w_lo[8] ? w_hi1[8] : w_hi0[8];
   end

   // Next-state and datapath update for IDLE -> RUN -> DONE sequencing
   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      result_d    = result_q;
      carry_d     = carry_q;
      idx_d       = idx_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start_valid) begin
               // Subtract is A + ~B + 1, so borrow-in becomes an inverted carry-in
               op_a_d  = bus.a;
               op_b_d  = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? ~bus.carryIn : bus.carryIn;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            result_d[16*idx_q +: 16] = w_sum;
            carry_d                  = w_cout;
            if (idx_q == IDX_LAST) begin
               carry_out_d = w_cout;
               // Operand signs use the already-inverted B for subtraction
               overflow_d  = (op_a_q[N-1] == op_b_q[N-1]) && (w_sum[15] != op_a_q[N-1]);
               state_d     = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         S_DONE: begin
            if (bus.done_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset overrides everything in any state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
      end
   end

   // start_ready is masked by rst so no command is taken during reset
   assign bus.start_ready = (state_q == S_IDLE) && !rst;
   assign bus.busy        = (state_q == S_RUN);
   assign bus.done_valid  = (state_q == S_DONE);
   assign bus.result      = result_q;
   assign bus.carryOut    = carry_out_q;
   assign bus.overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
// ============================================================================
//  Module      : tb_wide_add_sequencer
//  Description : Directed, table-driven bench for wide_add_sequencer with
//                WORDS = 4, plus backpressure and mid-run reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wide_add_sequencer;

   localparam int WORDS = 4;

   logic clk;
   logic rst;

   wide_add_sequencer_if #(.WORDS(WORDS)) bus ();

   wide_add_sequencer #(.WORDS(WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        sub;
      logic        cin;
      logic [63:0] exp_result;
      logic        exp_cout;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs [10];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   // Accept one command; returns cycles from accept until done_valid and RUN cycle count
   task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic s,
                         input logic ci, output int lat, output int busy_cnt);
      bus.a = a; bus.b = b; bus.sub = s; bus.carryIn = ci; bus.start_valid = 1'b1;
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
      bus.a = '1; bus.b = '1; bus.sub = ~s; bus.carryIn = ~ci;
      lat = 1; busy_cnt = 0;
      while (!bus.done_valid && lat < 50) begin
         if (bus.busy) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic finish_op(input string tag);
      bus.done_ready = 1'b1;
      @(posedge clk); #1;
      bus.done_ready = 1'b0;
      check({tag, " done_valid after handshake"}, {63'd0, bus.done_valid}, 64'd0);
      check({tag, " start_ready after handshake"}, {63'd0, bus.start_ready}, 64'd1);
   endtask

   task automatic do_op(input string tag, input vec_t v);
      int lat, bc;
      check({tag, " start_ready before"}, {63'd0, bus.start_ready}, 64'd1);
      launch(v.a, v.b, v.sub, v.cin, lat, bc);
      check({tag, " latency"},  64'(lat), 64'd5);
      check({tag, " busy cycles"}, 64'(bc), 64'd4);
      check({tag, " result"},   bus.result, v.exp_result);
      check({tag, " carryOut"}, {63'd0, bus.carryOut}, {63'd0, v.exp_cout});
      check({tag, " overflow"}, {63'd0, bus.overflow}, {63'd0, v.exp_ovf});
      finish_op(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat, bc;
      vec_t v;

      vecs[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
      vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[3] = '{64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[4] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
      vecs[5] = '{64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0};
      vecs[6] = '{64'd10, 64'd3, 1'b1, 1'b0, 64'd7, 1'b1, 1'b0};
      vecs[7] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[8] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1,
                  64'h2222_2222_2222_2212, 1'b0, 1'b0};
      vecs[9] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                  64'h0000_0000_0000_0000, 1'b1, 1'b1};

      bus.start_valid = 1'b0; bus.done_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.carryIn = 1'b0;

      // Reset state
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("reset start_ready", {63'd0, bus.start_ready}, 64'd0);
      check("reset done_valid",  {63'd0, bus.done_valid},  64'd0);
      check("reset busy",        {63'd0, bus.busy},        64'd0);
      check("reset result",      bus.result,               64'd0);
      check("reset carryOut",    {63'd0, bus.carryOut},    64'd0);
      check("reset overflow",    {63'd0, bus.overflow},    64'd0);
      rst = 1'b0;
      #1;
      check("post-reset start_ready", {63'd0, bus.start_ready}, 64'd1);

      // Table-driven vectors
      for (int i = 0; i < 10; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i]);
      end

      // Backpressure: result held while new commands are presented
      launch(64'd3, 64'd4, 1'b0, 1'b0, lat, bc);
      check("bp latency", 64'(lat), 64'd5);
      for (int k = 0; k < 3; k++) begin
         bus.a = 64'd100; bus.b = 64'd200; bus.sub = 1'b0; bus.carryIn = 1'b0;
         bus.start_valid = (k != 1);
         @(posedge clk); #1;
         check($sformatf("bp%0d done_valid", k),  {63'd0, bus.done_valid},  64'd1);
         check($sformatf("bp%0d result", k),      bus.result,               64'd7);
         check($sformatf("bp%0d start_ready", k), {63'd0, bus.start_ready}, 64'd0);
      end
      bus.start_valid = 1'b0;
      finish_op("bp");
      check("bp no queued command", {63'd0, bus.busy}, 64'd0);
      v = '{64'd100, 64'd200, 1'b0, 1'b0, 64'd300, 1'b0, 1'b0};
      do_op("bp next", v);

      // done_ready held high in advance does not shorten latency
      bus.done_ready = 1'b1;
      launch(64'd1, 64'd1, 1'b0, 1'b0, lat, bc);
      check("early ready latency", 64'(lat), 64'd5);
      check("early ready result",  bus.result, 64'd2);
      @(posedge clk); #1;
      bus.done_ready = 1'b0;
      check("early ready start_ready", {63'd0, bus.start_ready}, 64'd1);

      // Reset in the middle of RUN at idx = 2
      bus.a = 64'h1111_1111_1111_1111; bus.b = 64'h1111_1111_1111_1111;
      bus.sub = 1'b0; bus.carryIn = 1'b0; bus.start_valid = 1'b1;
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midrst busy before", {63'd0, bus.busy}, 64'd1);
      check("midrst partial result", bus.result, 64'h0000_0000_2222_2222);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("midrst busy",        {63'd0, bus.busy},        64'd0);
      check("midrst done_valid",  {63'd0, bus.done_valid},  64'd0);
      check("midrst result",      bus.result,               64'd0);
      check("midrst start_ready", {63'd0, bus.start_ready}, 64'd1);
      do_op("after midrst", vecs[5]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
